// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared types and constants for the cache-line to burst-memory adapter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package cacheline_adapter_pkg;

  localparam int unsigned BUS_WIDTH  = 64;
  localparam int unsigned BURST_LEN  = 4;
  localparam int unsigned LINE_WIDTH = BUS_WIDTH * BURST_LEN;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RD_BURST = 2'd1,
    ST_WR_BURST = 2'd2,
    ST_DONE     = 2'd3
  } state_e;

  // Bit offset of beat slot 'beat' inside a line: beat k lives at [k*W +: W].
  function automatic int unsigned beat_lsb(input int unsigned beat,
                                           input int unsigned bus_width);
    return beat * bus_width;
  endfunction

endpackage

// File: rtl/cacheline_burst_adapter_if.sv
// Cache-side (dfp) and memory-side (bmem) bundles for the line/burst adapter.
// Latency: n/a (wires only).
// Backpressure: request held until dfp_resp; burst held until the last bmem_resp.
interface cacheline_dfp_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = cacheline_adapter_pkg::LINE_WIDTH
) ();
  logic [ADDR_WIDTH-1:0] dfp_addr;
  logic                  dfp_read;
  logic                  dfp_write;
  logic [LINE_WIDTH-1:0] dfp_wdata;
  logic [LINE_WIDTH-1:0] dfp_rdata;
  logic                  dfp_resp;

  // Cache (requester) side.
  modport master (
    output dfp_addr, dfp_read, dfp_write, dfp_wdata,
    input  dfp_rdata, dfp_resp
  );

  // Adapter (responder) side.
  modport slave (
    input  dfp_addr, dfp_read, dfp_write, dfp_wdata,
    output dfp_rdata, dfp_resp
  );
endinterface

interface cacheline_bmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int BUS_WIDTH  = cacheline_adapter_pkg::BUS_WIDTH
) ();
  logic [ADDR_WIDTH-1:0] bmem_addr;
  logic                  bmem_read;
  logic                  bmem_write;
  logic [BUS_WIDTH-1:0]  bmem_wdata;
  logic [BUS_WIDTH-1:0]  bmem_rdata;
  logic                  bmem_resp;

  // Adapter (burst initiator) side.
  modport master (
    output bmem_addr, bmem_read, bmem_write, bmem_wdata,
    input  bmem_rdata, bmem_resp
  );

  // Memory side.
  modport slave (
    input  bmem_addr, bmem_read, bmem_write, bmem_wdata,
    output bmem_rdata, bmem_resp
  );
endinterface

// File: rtl/cacheline_burst_adapter.sv
// Converts one 256-bit line read/write into a line-aligned 4x64-bit memory burst (optional watchdog: CACHELINE_ADAPTER_WATCHDOG_EN).
// Latency: burst starts 1 cycle after request; dfp_resp 1 cycle after the last beat edge (2 cycles overhead).
// Backpressure: single outstanding transaction; request held until dfp_resp, memory paces beats via bmem_resp.
module cacheline_burst_adapter
  import cacheline_adapter_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int BUS_WIDTH      = cacheline_adapter_pkg::BUS_WIDTH,
  parameter int BURST_LEN      = cacheline_adapter_pkg::BURST_LEN,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 rst_n,
  cacheline_dfp_if.slave       dfp,
  cacheline_bmem_if.master     bmem,
  output logic                 error
);

  localparam int LINE_WIDTH = BUS_WIDTH * BURST_LEN;
  localparam int LINE_BYTES = LINE_WIDTH / 8;
  localparam int BEAT_W     = $clog2(BURST_LEN);
  localparam int WDOG_W     = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK = ADDR_WIDTH'(LINE_BYTES - 1);
  localparam logic [BEAT_W-1:0]     LAST_BEAT   = BEAT_W'(BURST_LEN - 1);

  state_e                r_state;
  state_e                w_state_nxt;
  logic [BEAT_W-1:0]     r_beat;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [LINE_WIDTH-1:0] r_wline;
  logic [LINE_WIDTH-1:0] r_rdata;
  logic                  r_error;

  logic                  w_rd_req;
  logic                  w_wr_req;
  logic                  w_in_burst;
  logic                  w_last_resp;
  logic                  w_timeout;
  logic                  w_proto_err;
  logic [WDOG_W-1:0]     w_wdog_cnt;
  logic                  w_bmem_read;
  logic                  w_bmem_write;
  logic                  w_dfp_resp;
  logic [BUS_WIDTH-1:0]  w_bmem_wdata;

  // A request is only accepted when exactly one of read/write is asserted.
  assign w_rd_req    = dfp.dfp_read & ~dfp.dfp_write;
  assign w_wr_req    = dfp.dfp_write & ~dfp.dfp_read;
  assign w_in_burst  = (r_state == ST_RD_BURST) || (r_state == ST_WR_BURST);
  assign w_last_resp = w_in_burst && bmem.bmem_resp && (r_beat == LAST_BEAT);

  // Protocol violations: conflicting request, or a beat response with no burst open.
  assign w_proto_err = ((r_state == ST_IDLE) && dfp.dfp_read && dfp.dfp_write) ||
                       (((r_state == ST_IDLE) || (r_state == ST_DONE)) && bmem.bmem_resp);

`ifdef CACHELINE_ADAPTER_WATCHDOG_EN
  logic [WDOG_W-1:0] r_wdog_cnt;

  // Cycles since the last beat response in the current burst; cleared outside bursts.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdog_cnt <= '0;
    end else if (!w_in_burst || bmem.bmem_resp || w_timeout) begin
      r_wdog_cnt <= '0;
    end else begin
      r_wdog_cnt <= r_wdog_cnt + WDOG_W'(1);
    end
  end

  assign w_wdog_cnt = r_wdog_cnt;
`else
  // Without the watchdog the count is tied to zero, so the timeout compare is constant-false.
  assign w_wdog_cnt = '0;
`endif

  assign w_timeout = w_in_burst && (w_wdog_cnt == WDOG_W'(TIMEOUT_CYCLES));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and state-decoded outputs.
  always_comb begin
    w_state_nxt  = r_state;
    w_bmem_read  = 1'b0;
    w_bmem_write = 1'b0;
    w_dfp_resp   = 1'b0;
    w_bmem_wdata = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_rd_req) begin
          w_state_nxt = ST_RD_BURST;
        end else if (w_wr_req) begin
          w_state_nxt = ST_WR_BURST;
        end
      end
      ST_RD_BURST: begin
        w_bmem_read = 1'b1;
        if (w_timeout || w_last_resp) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_WR_BURST: begin
        w_bmem_write = 1'b1;
        w_bmem_wdata = r_wline[beat_lsb(int'(r_beat), BUS_WIDTH) +: BUS_WIDTH];
        if (w_timeout || w_last_resp) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_dfp_resp  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Beat counter: cleared on acceptance, advances per beat, wraps to 0 on the last beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_beat <= '0;
    end else if (r_state == ST_IDLE) begin
      r_beat <= '0;
    end else if (w_timeout) begin
      r_beat <= '0;
    end else if (w_in_burst && bmem.bmem_resp) begin
      r_beat <= r_beat + BEAT_W'(1);
    end
  end

  // Latch the line-aligned address and the write line when a request is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wline <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_rd_req || w_wr_req) begin
        r_addr <= dfp.dfp_addr & ~OFFSET_MASK;
      end
      if (w_wr_req) begin
        r_wline <= dfp.dfp_wdata;
      end
    end
  end

  // Assemble read beats into the returned line; a timed-out read returns zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_timeout && (r_state == ST_RD_BURST)) begin
      r_rdata <= '0;
    end else if ((r_state == ST_RD_BURST) && bmem.bmem_resp) begin
      r_rdata[beat_lsb(int'(r_beat), BUS_WIDTH) +: BUS_WIDTH] <= bmem.bmem_rdata;
    end
  end

  // Sticky error flag; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_error <= 1'b0;
    end else if (w_proto_err || w_timeout) begin
      r_error <= 1'b1;
    end
  end

  assign bmem.bmem_addr  = r_addr;
  assign bmem.bmem_read  = w_bmem_read;
  assign bmem.bmem_write = w_bmem_write;
  assign bmem.bmem_wdata = w_bmem_wdata;
  assign dfp.dfp_rdata   = r_rdata;
  assign dfp.dfp_resp    = w_dfp_resp;
  assign error           = r_error;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench for cacheline_burst_adapter: transaction table plus reset/error/watchdog sequences.
// Latency: checks request->burst of 1 cycle and last-beat->dfp_resp of 1 cycle.
// Backpressure: memory model inserts per-table idle cycles between beats.
module tb_cacheline_burst_adapter;

  localparam int TIMEOUT = 16;

  logic clk;
  logic rst_n;
  logic error;

  cacheline_dfp_if  #(.ADDR_WIDTH(32), .LINE_WIDTH(256)) dfp ();
  cacheline_bmem_if #(.ADDR_WIDTH(32), .BUS_WIDTH(64))   bmem ();

  cacheline_burst_adapter #(
    .ADDR_WIDTH    (32),
    .BUS_WIDTH     (64),
    .BURST_LEN     (4),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .dfp  (dfp.slave),
    .bmem (bmem.master),
    .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  int n_overlap = 0;
  int n_resp = 0;

  // Memory model contents, keyed by line address.
  logic [255:0] mem [logic [31:0]];

  always @(negedge clk) begin
    if (bmem.bmem_read && bmem.bmem_write) n_overlap++;
    if (dfp.dfp_resp) n_resp++;
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    bit           is_wr;
    logic [31:0]  addr;
    logic [255:0] wline;
    logic [31:0]  exp_addr;
    logic [255:0] exp_rdata;
    int           lat;
  } vec_t;

  localparam logic [255:0] LINE_A = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
  localparam logic [255:0] LINE_B = {64'h8888_8888_8888_8888, 64'h7777_7777_7777_7777,
                                     64'h6666_6666_6666_6666, 64'h5555_5555_5555_5555};
  localparam logic [255:0] LINE_W = {64'h0f0f_0f0f_f0f0_f0f0, 64'hdead_beef_cafe_f00d,
                                     64'hfedc_ba98_7654_3210, 64'h0123_4567_89ab_cdef};
  localparam logic [255:0] LINE_X = {64'ha5a5_a5a5_0000_0003, 64'ha5a5_a5a5_0000_0002,
                                     64'ha5a5_a5a5_0000_0001, 64'ha5a5_a5a5_0000_0000};

  vec_t vecs [5];

  // One full transaction starting at the current negedge; memory waits 'lat' cycles before each beat.
  task automatic run_txn(input vec_t v, input string nm);
    logic [255:0] mline;
    logic [255:0] cap;
    mline = 256'h0;
    cap   = 256'h0;
    dfp.dfp_addr  = v.addr;
    dfp.dfp_wdata = v.wline;
    dfp.dfp_read  = !v.is_wr;
    dfp.dfp_write = v.is_wr;
    @(negedge clk);
    chk({nm, " bmem_read start"},  {255'h0, bmem.bmem_read},  {255'h0, !v.is_wr});
    chk({nm, " bmem_write start"}, {255'h0, bmem.bmem_write}, {255'h0, v.is_wr});
    chk({nm, " bmem_addr"}, {224'h0, bmem.bmem_addr}, {224'h0, v.exp_addr});
    if (mem.exists(bmem.bmem_addr)) mline = mem[bmem.bmem_addr];
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < v.lat; w++) begin
        bmem.bmem_resp = 1'b0;
        @(negedge clk);
        chk({nm, " burst held"}, {254'h0, bmem.bmem_read, bmem.bmem_write},
            {254'h0, !v.is_wr, v.is_wr});
      end
      chk({nm, " addr stable"}, {224'h0, bmem.bmem_addr}, {224'h0, v.exp_addr});
      if (v.is_wr) begin
        chk($sformatf("%s wdata beat%0d", nm, k), {192'h0, bmem.bmem_wdata},
            {192'h0, v.wline[k*64 +: 64]});
        cap[k*64 +: 64] = bmem.bmem_wdata;
      end
      bmem.bmem_rdata = mline[k*64 +: 64];
      bmem.bmem_resp  = 1'b1;
      @(negedge clk);
    end
    bmem.bmem_resp = 1'b0;
    if (v.is_wr) mem[v.exp_addr] = cap;
    chk({nm, " dfp_resp"}, {255'h0, dfp.dfp_resp}, 256'h1);
    chk({nm, " dfp_rdata"}, dfp.dfp_rdata, v.exp_rdata);
    chk({nm, " burst dropped"}, {254'h0, bmem.bmem_read, bmem.bmem_write}, 256'h0);
    dfp.dfp_read  = 1'b0;
    dfp.dfp_write = 1'b0;
    @(negedge clk);
    chk({nm, " dfp_resp single"}, {255'h0, dfp.dfp_resp}, 256'h0);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, " bmem_read"},  {255'h0, bmem.bmem_read},  256'h0);
    chk({nm, " bmem_write"}, {255'h0, bmem.bmem_write}, 256'h0);
    chk({nm, " bmem_addr"},  {224'h0, bmem.bmem_addr},  256'h0);
    chk({nm, " bmem_wdata"}, {192'h0, bmem.bmem_wdata}, 256'h0);
    chk({nm, " dfp_resp"},   {255'h0, dfp.dfp_resp},    256'h0);
    chk({nm, " dfp_rdata"},  dfp.dfp_rdata,             256'h0);
    chk({nm, " error"},      {255'h0, error},           256'h0);
  endtask

  initial begin
    int cnt;
    vec_t rv;

    vecs[0] = '{1'b0, 32'h0000_1234, 256'h0,  32'h0000_1220, LINE_A, 0};
    vecs[1] = '{1'b1, 32'h8000_0040, LINE_W,  32'h8000_0040, LINE_A, 1};
    vecs[2] = '{1'b0, 32'h8000_005F, 256'h0,  32'h8000_0040, LINE_W, 2};
    vecs[3] = '{1'b0, 32'h0000_2000, 256'h0,  32'h0000_2000, LINE_B, 0};
    vecs[4] = '{1'b1, 32'h0000_303F, LINE_X,  32'h0000_3020, LINE_B, 0};
    mem[32'h0000_1220] = LINE_A;
    mem[32'h0000_2000] = LINE_B;

    rst_n = 1'b0;
    dfp.dfp_addr = 32'h0; dfp.dfp_read = 1'b0; dfp.dfp_write = 1'b0; dfp.dfp_wdata = 256'h0;
    bmem.bmem_rdata = 64'h0; bmem.bmem_resp = 1'b0;
    #1;
    check_reset_state("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven transactions, issued back to back.
    n_resp = 0;
    for (int i = 0; i < 5; i++) begin
      run_txn(vecs[i], $sformatf("vec%0d", i));
    end
    chk("resp pulse count", n_resp, 5);
    chk("no read/write overlap", n_overlap, 0);
    chk("no error after clean traffic", {255'h0, error}, 256'h0);

    // Conflicting read+write in IDLE: no bus activity, sticky error.
    dfp.dfp_read = 1'b1; dfp.dfp_write = 1'b1; dfp.dfp_addr = 32'h0000_4000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("both-req no bus", {253'h0, bmem.bmem_read, bmem.bmem_write, dfp.dfp_resp}, 256'h0);
    end
    chk("both-req error", {255'h0, error}, 256'h1);
    dfp.dfp_read = 1'b0; dfp.dfp_write = 1'b0;
    repeat (3) @(negedge clk);
    chk("error sticky", {255'h0, error}, 256'h1);
    rst_n = 1'b0;
    #1;
    chk("error cleared by reset", {255'h0, error}, 256'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Beat response with no burst open.
    bmem.bmem_resp = 1'b1;
    @(negedge clk);
    bmem.bmem_resp = 1'b0;
    chk("stray resp error", {255'h0, error}, 256'h1);
    chk("stray resp no dfp_resp", {255'h0, dfp.dfp_resp}, 256'h0);
    rst_n = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset after beat 1 of a read, then a clean read.
    dfp.dfp_addr = 32'h0000_1234; dfp.dfp_read = 1'b1;
    @(negedge clk);
    bmem.bmem_rdata = 64'h1111_1111_1111_1111; bmem.bmem_resp = 1'b1;
    @(negedge clk);
    bmem.bmem_rdata = 64'h2222_2222_2222_2222;
    @(negedge clk);
    bmem.bmem_resp = 1'b0;
    chk("mid-read bmem_read before reset", {255'h0, bmem.bmem_read}, 256'h1);
    rst_n = 1'b0;
    #1;
    check_reset_state("mid-read reset");
    dfp.dfp_read = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle after reset", {254'h0, bmem.bmem_read, dfp.dfp_resp}, 256'h0);
    rv = '{1'b0, 32'h0000_1234, 256'h0, 32'h0000_1220, LINE_A, 1};
    run_txn(rv, "post-reset read");

    // Silent memory: watchdog fires after TIMEOUT+1 cycles, or adapter waits forever.
    dfp.dfp_addr = 32'h0000_5000; dfp.dfp_read = 1'b1;
    @(negedge clk);
    chk("silent bmem_read", {255'h0, bmem.bmem_read}, 256'h1);
    dfp.dfp_read = 1'b1;
    cnt = 0;
    while (!dfp.dfp_resp && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
`ifdef CACHELINE_ADAPTER_WATCHDOG_EN
    chk("watchdog resp delay", cnt, TIMEOUT + 1);
    chk("watchdog rdata", dfp.dfp_rdata, 256'h0);
    chk("watchdog error", {255'h0, error}, 256'h1);
    dfp.dfp_read = 1'b0;
    @(negedge clk);
    chk("watchdog resp single", {255'h0, dfp.dfp_resp}, 256'h0);
`else
    chk("no watchdog: no resp", cnt, 40);
    chk("no watchdog: still reading", {255'h0, bmem.bmem_read}, 256'h1);
    chk("no watchdog: no error", {255'h0, error}, 256'h0);
    dfp.dfp_read = 1'b0;
`endif
    rst_n = 1'b0;
    #1;
    check_reset_state("final reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
